// File: rtl/scale_addr_gen.sv
// scale_addr_gen: maps display (hcount, vcount) to a frame-buffer read address
// at 1x, 2x or 8/3x zoom. Two-stage address pipeline (source coordinates +
// window test, then row*FB_WIDTH+col), with counts and scale delayed by
// 2+BRAM_LATENCY cycles to line up with frame-buffer read data.
// Optional macro SCALE_FRAME_LATCH_EN: the scale only changes at the top of a
// frame (hcount_in==0 && vcount_in==0) instead of every cycle.
module scale_addr_gen #(
  parameter int unsigned FB_WIDTH     = 240,
  parameter int unsigned FB_HEIGHT    = 320,
  parameter int unsigned BRAM_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [1:0]  scale_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  output logic [16:0] addr_out,
  output logic        in_window_out,
  output logic [1:0]  scale_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);

  localparam int unsigned DLY = 2 + BRAM_LATENCY;

  logic [1:0]  scale_q;

  logic [12:0] h3;
  logic [11:0] v3;
  logic [10:0] xs_d;
  logic [9:0]  ys_d;
  logic [10:0] wlim;
  logic [9:0]  hlim;
  logic        win_d;

  logic [10:0] s1_xs;
  logic [9:0]  s1_ys;
  logic        s1_win;
  logic [1:0]  s1_scale;

  logic [16:0] addr_d;

  logic [10:0] h_dly  [DLY];
  logic [9:0]  v_dly  [DLY];
  logic [1:0]  sc_dly [DLY-1];

`ifdef SCALE_FRAME_LATCH_EN
  // Active scale: reloaded only at the first pixel of a frame
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      scale_q <= '0;
    else if (hcount_in == '0 && vcount_in == '0)
      scale_q <= scale_in;
  end
`else
  // Active scale: registered pass-through of scale_in
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)
      scale_q <= '0;
    else
      scale_q <= scale_in;
  end
`endif

  // Source coordinates and window test for the current scale
  always_comb begin
    h3    = ({2'b00, hcount_in} << 1) + {2'b00, hcount_in};
    v3    = ({2'b00, vcount_in} << 1) + {2'b00, vcount_in};
    xs_d  = hcount_in;
    ys_d  = vcount_in;
    wlim  = 11'd240;
    hlim  = 10'd320;
    case (scale_q)
      2'b00: begin
        xs_d = hcount_in;
        ys_d = vcount_in;
        wlim = 11'd240;
        hlim = 10'd320;
      end
      2'b01: begin
        xs_d = hcount_in >> 1;
        ys_d = vcount_in >> 1;
        wlim = 11'd480;
        hlim = 10'd640;
      end
      default: begin
        xs_d = 11'(h3 >> 3);
        ys_d = 10'(v3 >> 3);
        wlim = 11'd640;
        hlim = 10'd853;
      end
    endcase
    // The source-range terms keep the address inside the buffer even for
    // non-default FB_WIDTH/FB_HEIGHT; with defaults they are always true.
    win_d = (hcount_in < wlim) && (vcount_in < hlim) &&
            (32'(xs_d) < FB_WIDTH) && (32'(ys_d) < FB_HEIGHT);
  end

  // Stage 1 register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_xs    <= '0;
      s1_ys    <= '0;
      s1_win   <= 1'b0;
      s1_scale <= '0;
    end else begin
      s1_xs    <= xs_d;
      s1_ys    <= ys_d;
      s1_win   <= win_d;
      s1_scale <= scale_q;
    end
  end

  // Linear address; shift-subtract form for the 240-wide buffer
  generate
    if (FB_WIDTH == 240) begin : g_addr_240
      always_comb begin
        addr_d = (17'(s1_ys) << 8) - (17'(s1_ys) << 4) + 17'(s1_xs);
      end
    end else begin : g_addr_mul
      always_comb begin
        addr_d = 17'(32'(s1_ys) * FB_WIDTH) + 17'(s1_xs);
      end
    end
  endgenerate

  // Stage 2 register: address forced to 0 outside the window
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      addr_out      <= '0;
      in_window_out <= 1'b0;
    end else begin
      addr_out      <= s1_win ? addr_d : '0;
      in_window_out <= s1_win;
    end
  end

  // Count and scale delay lines aligned with frame-buffer read data
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < DLY; i++) begin
        h_dly[i] <= '0;
        v_dly[i] <= '0;
      end
      for (int unsigned i = 0; i < DLY - 1; i++)
        sc_dly[i] <= '0;
    end else begin
      h_dly[0]  <= hcount_in;
      v_dly[0]  <= vcount_in;
      sc_dly[0] <= s1_scale;
      for (int unsigned i = 1; i < DLY; i++) begin
        h_dly[i] <= h_dly[i-1];
        v_dly[i] <= v_dly[i-1];
      end
      for (int unsigned i = 1; i < DLY - 1; i++)
        sc_dly[i] <= sc_dly[i-1];
    end
  end

  assign hcount_out = h_dly[DLY-1];
  assign vcount_out = v_dly[DLY-1];
  // s1_scale already carries one cycle of delay
  assign scale_out  = sc_dly[DLY-2];

endmodule
